// File: rtl/uart_tx_dev_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// base address and serializer state encodings.
package uart_tx_dev_pkg;

    localparam logic [31:0] UART_BASE_ADDR = 32'h0000_7F30;

    localparam logic [1:0] UART_DATA = 2'd0;
    localparam logic [1:0] UART_STAT = 2'd1;
    localparam logic [1:0] UART_CTRL = 2'd2;
    localparam logic [1:0] UART_DIV  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // A programmed divisor of 0 would stall the bit counter, so it runs as 1.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO between the CPU store path and the serializer; storage is not reset,
// only pointers and occupancy are.
module uart_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Fullness uses the pre-edge count, so a push into a full FIFO is dropped
    // even when a pop happens in the same cycle.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: register decode, baud counter and
// serializer FSM in front of a small byte FIFO.
module uart_tx_dev
    import uart_tx_dev_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = UART_BASE_ADDR,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        tx,
    output logic        IRQ
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    uart_state_t   state, state_nxt;
    logic [15:0]   cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          tx_nxt;
    logic [15:0]   bit_len;
    logic          pop;
    logic          frame_end;

    logic          hit;
    logic [1:0]    reg_sel;
    logic          wr_data, wr_stat, wr_ctrl, wr_div;
    logic          push_ok;

    logic          en, ie;
    logic [15:0]   divisor;
    logic          overflow, done;

    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic [2:0]    stat_cnt;
    logic          unused_din;

    assign hit        = (Addr[29:2] == BASE_ADDR[31:4]);
    assign reg_sel    = Addr[1:0];
    assign wr_data    = WE & hit & (reg_sel == UART_DATA);
    assign wr_stat    = WE & hit & (reg_sel == UART_STAT);
    assign wr_ctrl    = WE & hit & (reg_sel == UART_CTRL);
    assign wr_div     = WE & hit & (reg_sel == UART_DIV);
    assign push_ok    = wr_data & ~fifo_full;
    assign stat_cnt   = 3'(fifo_count);
    assign unused_din = ^Din[31:16];

    uart_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .pop   (pop),
        .din   (Din[7:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        Dout = '0;
        if (hit) begin
            case (reg_sel)
                UART_STAT: Dout[7:0]  = {stat_cnt, done, overflow, fifo_full,
                                         fifo_empty, (state != ST_IDLE)};
                UART_CTRL: Dout[1:0]  = {ie, en};
                UART_DIV:  Dout[15:0] = divisor;
                default:   Dout       = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en       <= 1'b0;
            ie       <= 1'b0;
            divisor  <= DIV_RESET;
            overflow <= 1'b0;
            done     <= 1'b0;
            IRQ      <= 1'b0;
        end else begin
            if (wr_ctrl) {ie, en} <= Din[1:0];
            if (wr_div)  divisor  <= Din[15:0];
            if (wr_data && fifo_full) overflow <= 1'b1;
            else if (wr_stat)         overflow <= 1'b0;
            // A frame ending on an empty FIFO outranks a same-cycle clear.
            if (frame_end && fifo_empty)  done <= 1'b1;
            else if (wr_stat || push_ok)  done <= 1'b0;
            IRQ <= ie & done;
        end
    end

    // Divisor is sampled at each bit start, so mid-frame writes apply from the next bit.
    assign bit_len = eff_div(divisor) - 16'd1;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        pop         = 1'b0;
        frame_end   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && !fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_dout;
                    cnt_nxt   = bit_len;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (cnt == 16'd0) begin
                    state_nxt   = ST_DATA;
                    bit_idx_nxt = 3'd0;
                    cnt_nxt     = bit_len;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt == 16'd0) begin
                    cnt_nxt = bit_len;
                    if (bit_idx == 3'd7) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        shift_nxt   = {1'b0, shift[7:1]};
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt == 16'd0) begin
                    state_nxt = ST_IDLE;
                    frame_end = 1'b1;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        case (state_nxt)
            ST_START: tx_nxt = 1'b0;
            ST_DATA:  tx_nxt = shift_nxt[0];
            default:  tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            tx      <= tx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_nxt;
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev: bytes written to DATA are queued as expected
// frames and checked bit by bit against the tx line.
module tb_uart_tx_dev;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        tx;
    logic        IRQ;

    localparam logic [29:0] A_DATA = 30'h1FCC;
    localparam logic [29:0] A_STAT = 30'h1FCD;
    localparam logic [29:0] A_CTRL = 30'h1FCE;
    localparam logic [29:0] A_DIV  = 30'h1FCF;
    localparam logic [29:0] A_NONE = 30'h0000;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] sb[$];

    uart_tx_dev dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .tx    (tx),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
        Addr = A_NONE;
    endtask

    task automatic rd_chk(input string tag, input logic [29:0] a, input logic [31:0] exp);
        @(negedge clk);
        Addr = a;
        #1;
        check(tag, Dout, exp);
    endtask

    // Waits for the start bit, then checks every cycle of the frame. Bit widths are
    // div_a up to frame position chg_pos and div_b after; a DIVISOR write of div_b
    // is issued during position chg_pos when chg_pos < 10.
    task automatic check_frame(input int div_a, input int div_b, input int chg_pos, input int exp_lat);
        logic [7:0] exp_b;
        logic [7:0] got_b;
        logic       ok;
        logic       bit_e;
        logic       pending;
        int         lat;
        int         w;
        Addr    = A_STAT;
        WE      = 1'b0;
        pending = 1'b0;
        got_b   = 8'h00;
        lat     = 0;
        do begin
            @(negedge clk);
            #1;
            lat++;
        end while (tx !== 1'b0 && lat < 400);
        check("frame_start", {31'b0, tx}, 32'd0);
        if (exp_lat > 0) check("start_latency", lat, exp_lat);
        if (tx !== 1'b0) return;
        if (sb.size() == 0) begin
            check("scoreboard_depth", sb.size(), 1);
            exp_b = 8'h00;
        end else begin
            exp_b = sb.pop_front();
        end
        for (int pos = 0; pos < 10; pos++) begin
            w  = (pos <= chg_pos) ? div_a : div_b;
            ok = 1'b1;
            for (int c = 0; c < w; c++) begin
                if (pos != 0 || c != 0) begin
                    @(negedge clk);
                    if (pending) begin
                        WE      = 1'b0;
                        Addr    = A_STAT;
                        pending = 1'b0;
                    end
                    #1;
                end
                bit_e = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : exp_b[pos-1];
                if (tx !== bit_e || Dout[0] !== 1'b1 || IRQ !== 1'b0) ok = 1'b0;
                if (c == 0 && pos >= 1 && pos <= 8) got_b[pos-1] = tx;
                if (pos == chg_pos && c == 1) begin
                    Addr    = A_DIV;
                    Din     = div_b;
                    WE      = 1'b1;
                    pending = 1'b1;
                end
            end
            check($sformatf("frame_pos%0d", pos), {31'b0, ok}, 32'd1);
        end
        check("frame_byte", {24'b0, got_b}, {24'b0, exp_b});
    endtask

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = A_NONE;
        Din   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_irq", {31'b0, IRQ}, 32'd0);
        reset = 1'b0;
        rd_chk("rst_status", A_STAT, 32'h02);
        rd_chk("rst_div", A_DIV, 32'h10);
        rd_chk("rst_ctrl", A_CTRL, 32'h0);

        // Single byte at DIV=4
        wr(A_DIV, 32'd4);
        wr(A_CTRL, 32'h1);
        sb.push_back(8'hA5);
        wr(A_DATA, 32'hA5);
        check_frame(4, 4, 10, 2);
        rd_chk("single_done_status", A_STAT, 32'h12);

        // Overflow with EN=0, then drain
        wr(A_CTRL, 32'h0);
        for (int i = 1; i <= 5; i++) wr(A_DATA, i);
        rd_chk("ovf_status", A_STAT, 32'h8C);
        for (int i = 1; i <= 4; i++) sb.push_back(8'(i));
        wr(A_CTRL, 32'h1);
        for (int i = 0; i < 4; i++) check_frame(4, 4, 10, 2);
        rd_chk("ovf_drained_status", A_STAT, 32'h1A);
        wr(A_STAT, 32'hFFFF_FFFF);
        rd_chk("ovf_cleared_status", A_STAT, 32'h02);
        check("sb_empty_after_ovf", sb.size(), 0);

        // Interrupt after two back-to-back frames
        wr(A_DIV, 32'd2);
        wr(A_CTRL, 32'h3);
        sb.push_back(8'h3C);
        sb.push_back(8'h5A);
        wr(A_DATA, 32'h3C);
        wr(A_DATA, 32'h5A);
        check_frame(2, 2, 10, -1);
        check_frame(2, 2, 10, 2);
        @(negedge clk);
        #1;
        check("irq_lags_done", {31'b0, IRQ}, 32'd0);
        check("done_after_burst", {31'b0, Dout[4]}, 32'd1);
        @(negedge clk);
        #1;
        check("irq_rises", {31'b0, IRQ}, 32'd1);
        wr(A_STAT, 32'h0);
        @(negedge clk);
        #1;
        check("irq_held_one_cycle", {31'b0, IRQ}, 32'd1);
        @(negedge clk);
        #1;
        check("irq_drops", {31'b0, IRQ}, 32'd0);

        // Divisor 0 runs as 1, then a mid-frame change 8 -> 2 during bit 3
        wr(A_CTRL, 32'h1);
        wr(A_DIV, 32'd0);
        rd_chk("div_zero_readback", A_DIV, 32'h0);
        sb.push_back(8'h96);
        wr(A_DATA, 32'h96);
        check_frame(1, 1, 10, 2);
        rd_chk("div_zero_done", A_STAT, 32'h12);
        wr(A_DIV, 32'd8);
        sb.push_back(8'h4B);
        wr(A_DATA, 32'h4B);
        check_frame(8, 2, 4, 2);
        rd_chk("div_changed_readback", A_DIV, 32'h2);

        // Address decode
        wr(30'h1FD0, 32'h77);
        wr(30'h1FC0, 32'h55);
        wr(30'h1FD2, 32'h0);
        wr(30'h1FD1, 32'h0);
        rd_chk("decode_status", A_STAT, 32'h12);
        rd_chk("decode_ctrl", A_CTRL, 32'h1);
        rd_chk("decode_nomatch_read", 30'h1FD1, 32'h0);
        rd_chk("decode_low_read", 30'h1FC3, 32'h0);
        rd_chk("data_read_zero", A_DATA, 32'h0);
        repeat (4) @(negedge clk);
        #1;
        check("decode_tx_idle", {31'b0, tx}, 32'd1);

        // Reset in the middle of a frame
        wr(A_DIV, 32'd4);
        wr(A_DATA, 32'h00);
        repeat (8) @(negedge clk);
        #1;
        check("midframe_tx_low", {31'b0, tx}, 32'd0);
        reset = 1'b1;
        #1;
        check("midframe_rst_tx", {31'b0, tx}, 32'd1);
        check("midframe_rst_irq", {31'b0, IRQ}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd_chk("midframe_rst_status", A_STAT, 32'h02);
        rd_chk("midframe_rst_div", A_DIV, 32'h10);
        rd_chk("midframe_rst_ctrl", A_CTRL, 32'h0);
        @(negedge clk);
        #1;
        check("midframe_tx_idle", {31'b0, tx}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
